cla_pipe_adder: RTL
===================

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are multiples of GROUP, 4..64.
REQ-002 SHALL have parameter GROUP, default 4, bits per lookahead group (one group = GROUP bit-slice cells).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b, sub, cin valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port sub  input  1  1 = A - B (B inverted, carry-in forced 1); 0 = A + B + cin.
REQ-010 SHALL have port cin  input  1  carry-in; ignored when sub = 1.
REQ-011 SHALL have port out_valid  output  1  result fields valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-013 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-015 SHALL have port zero  output  1  sum == 0.
REQ-016 SHALL have port ovf  output  1  signed overflow (see Configuration).

Function
REQ-017 SHALL be a two-stage pipeline: S1 registers operands, per-bit p = x|y, g = x&y, and per-group G/P; S2 computes group carries by lookahead from registered G/P and cin, forms sum = x^y^c, registers outputs.
REQ-018 SHALL have latency exactly 2 cycles from accept (in_valid & in_ready) to out_valid when out_ready stays 1.
REQ-019 SHALL sustain one accept per cycle when out_ready = 1.
REQ-020 SHALL drive in_ready = !(out_valid & !out_ready) | !s1_valid, i.e. S1 accepts when empty or when S1 can advance.
REQ-021 SHALL hold sum, cout, zero, ovf, out_valid stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL on stall hold S1 contents; a full S1 plus stalled S2 drops in_ready to 0 with no operand lost or duplicated.
REQ-023 SHALL allow simultaneous S2 retire and S1 advance and new accept in one cycle.
REQ-024 SHALL deliver results in issue order; each accepted operation produces exactly one result.
REQ-025 SHALL compute, with sub = 1, sum = (A - B) mod 2^WIDTH and cout = 1 iff A >= B unsigned.
REQ-026 SHALL drive out_valid = 0 with other outputs don't-care-free (hold last value) when pipeline empty.

Reset
REQ-027 SHALL on clr = 1 at a clock edge clear both stage valid bits, sum, cout, zero, ovf to 0; in_ready = 1 in the following cycle.
REQ-028 SHALL discard in-flight operations when clr asserts mid-operation; no result from them ever appears.
REQ-029 SHALL ignore in_valid in any cycle with clr = 1.

Configuration
REQ-030 SHALL, with macro CLA_OVF_EN defined, drive ovf = carry into bit WIDTH-1 XOR cout, registered with sum.
REQ-031 SHALL, without CLA_OVF_EN, tie ovf to 0 and synthesise no overflow logic; port list unchanged.

Verification
REQ-032 SHALL cover WIDTH=32: A=0xFFFFFFFF, B=1, sub=0, cin=0 -> sum=0, cout=1, zero=1, out_valid exactly 2 cycles after accept.
REQ-033 SHALL cover sub=1, A=5, B=7 -> sum=0xFFFFFFFE, cout=0, zero=0; A=7, B=7 -> sum=0, cout=1, zero=1.
REQ-034 SHALL cover CLA_OVF_EN defined: A=0x7FFFFFFF, B=1, sub=0 -> ovf=1, sum=0x80000000; undefined -> ovf=0.
REQ-035 SHALL cover back-to-back 3 ops with out_ready held 0 for 4 cycles -> in_ready drops after 2 accepts, results emerge in order, none lost.
REQ-036 SHALL cover clr asserted one cycle after accepting A=1, B=1 -> out_valid never rises for that op; next op (A=2, B=3) yields sum=5.
REQ-037 SHALL cover exhaustive WIDTH=4, GROUP=4, all A, B, cin, sub -> sum/cout match reference arithmetic.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Defining CLA_OVF_EN adds a registered signed-overflow flag; otherwise ovf is tied to 0.
`timescale 1ns/1ps
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);
    localparam int NGRP = WIDTH / GROUP;

    // Stage 1: per-bit propagate/generate plus per-group lookahead terms.
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] x_d, y_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             c0_q, c0_d;
    logic [NGRP-1:0]  gg_q, gg_d;
    logic [NGRP-1:0]  gp_q, gp_d;

    // Stage 2: carry resolution and registered results.
    logic [NGRP:0]    cg;
    logic [WIDTH:0]   cb;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;

    logic             s2_ready;
    logic             s1_advance;
    logic             accept;

    // S2 frees up when it is empty or its result is being taken this cycle.
    assign s2_ready    = !out_valid_q || out_ready;
    assign s1_advance  = s1_valid_q && s2_ready;
    assign in_ready    = !(out_valid_q && !out_ready) || !s1_valid_q;
    assign accept      = in_valid && in_ready && !clr;

    assign s1_valid_d  = accept || (s1_valid_q && !s2_ready);
    assign out_valid_d = s1_valid_q || (out_valid_q && !out_ready);

    always_comb begin : s1_prep
        // NOTE: every combinational output gets a default before any loop or branch, so no latch can be inferred.
        x_d  = a;
        y_d  = sub ? ~b : b;
        c0_d = sub | cin;
        p_d  = x_d | y_d;
        g_d  = x_d & y_d;
        gg_d = '0;
        gp_d = '1;
        for (int j = 0; j < NGRP; j++) begin
            for (int m = 0; m < GROUP; m++) begin
                gg_d[j] = g_d[j*GROUP+m] | (p_d[j*GROUP+m] & gg_d[j]);
                gp_d[j] = gp_d[j] & p_d[j*GROUP+m];
            end
        end
    end

    // Group carries in flattened lookahead form: each cg[j] depends only on registered G/P and c0.
    always_comb begin : group_lookahead
        logic term;
        term = 1'b0;
        cg   = '0;
        for (int j = 0; j <= NGRP; j++) begin
            term = c0_q;
            for (int k = 0; k < j; k++) begin
                term = term & gp_q[k];
            end
            cg[j] = term;
            for (int i = 0; i < j; i++) begin
                term = gg_q[i];
                for (int k = i + 1; k < j; k++) begin
                    term = term & gp_q[k];
                end
                cg[j] = cg[j] | term;
            end
        end
    end

    // Bit carries inside each group, again flattened from the group carry-in.
    always_comb begin : bit_lookahead
        logic term;
        int   base;
        term = 1'b0;
        base = 0;
        cb   = '0;
        for (int j = 0; j < NGRP; j++) begin
            base = j * GROUP;
            for (int m = 0; m < GROUP; m++) begin
                term = cg[j];
                for (int k = 0; k < m; k++) begin
                    term = term & p_q[base+k];
                end
                cb[base+m] = term;
                for (int i = 0; i < m; i++) begin
                    term = g_q[base+i];
                    for (int k = i + 1; k < m; k++) begin
                        term = term & p_q[base+k];
                    end
                    cb[base+m] = cb[base+m] | term;
                end
            end
        end
        cb[WIDTH] = cg[NGRP];
    end

    // p & ~g is x ^ y, so the registered p/g pair carries the operands into S2.
    always_comb begin : s2_result
        sum_d  = (p_q & ~g_q) ^ cb[WIDTH-1:0];
        cout_d = cb[WIDTH];
        zero_d = (sum_d == '0);
    end

    always_ff @(posedge clk) begin : ctrl_regs
        // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
        if (clr) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (s1_advance) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                zero_q <= zero_d;
            end
        end
    end

    always_ff @(posedge clk) begin : s1_data_regs
        // NOTE: stage-1 data has no reset; s1_valid_q qualifies it, so stale contents are never observed.
        if (accept) begin
            p_q  <= p_d;
            g_q  <= g_d;
            c0_q <= c0_d;
            gg_q <= gg_d;
            gp_q <= gp_d;
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_q, ovf_d;

    assign ovf_d = cb[WIDTH-1] ^ cb[WIDTH];

    always_ff @(posedge clk) begin : ovf_reg
        if (clr) begin
            ovf_q <= 1'b0;
        end else if (s1_advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule
